// File: rtl/serial_sub.sv
// Bit-serial subtractor: D = A - B over WIDTH clocks, LSB first, with borrow
// held in a flop between cycles. Start is also accepted on the final bit so
// that a held start chains operations every WIDTH cycles.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] d_o,
  output logic             bout_o,
  output logic             ovf_o
);

  // state  | meaning
  // S_IDLE | waiting for start; outputs hold the last result
  // S_RUN  | one operand bit per cycle, result published on the last bit
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             bor_q, bor_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d, ovf_q, ovf_d, done_q, done_d;

  logic             a_bit, b_bit, d_bit, bor_nxt, last, accept;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    bor_d   = bor_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    accept  = 1'b0;

    a_bit     = a_q[0];
    b_bit     = b_q[0];
    d_bit     = a_bit ^ b_bit ^ bor_q;
    bor_nxt   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bor_q);
    // New difference bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    res_shift = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
    last      = (cnt_q == CW'(WIDTH - 1));

    case (state_q)
      S_IDLE: accept = start_i;
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_shift;
        bor_d = bor_nxt;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          d_d     = res_shift;
          bout_d  = bor_nxt;
          ovf_d   = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
          done_d  = 1'b1;
          state_d = S_IDLE;
          accept  = start_i;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      a_d     = a_i;
      b_d     = b_i;
      a_msb_d = a_i[WIDTH-1];
      b_msb_d = b_i[WIDTH-1];
      res_d   = '0;
      bor_d   = 1'b0;
      cnt_d   = '0;
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      bor_q   <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      bor_q   <= bor_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q == S_RUN);
  assign done_o = done_q;
  assign d_o    = d_q;
  assign bout_o = bout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub at WIDTH=8 and WIDTH=1: expected results come
// from plain integer arithmetic on the accepted operands.
module tb_serial_sub;

  logic clk;
  int   tests = 0;
  int   fails = 0;
  bit   fin [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    bit          bo;
    bit          ov;
    int          due;
  } exp_t;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int W = (g == 0) ? 8 : 1;
    localparam logic [31:0] MASK = (32'd1 << W) - 32'd1;

    logic         rst, start, busy, done, bout, ovf;
    logic [W-1:0] a, b, d;

    serial_sub #(.WIDTH(W)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .start_i(start),
      .a_i    (a),
      .b_i    (b),
      .busy_o (busy),
      .done_o (done),
      .d_o    (d),
      .bout_o (bout),
      .ovf_o  (ovf)
    );

    exp_t        q[$];
    int          rem = 0;
    int          cyc = 0;
    bit          armed = 0;
    bit          rst_seen = 0;
    bit          exp_busy = 0;
    logic [31:0] last_d = 0;
    bit          last_bo = 0;
    bit          last_ov = 0;

    function automatic exp_t model(logic [31:0] ua, logic [31:0] ub, int due);
      exp_t   e;
      longint la, lb, sa, sb, diff, half;
      half  = longint'(1) << (W - 1);
      la    = longint'(ua);
      lb    = longint'(ub);
      sa    = (la >= half) ? la - 2 * half : la;
      sb    = (lb >= half) ? lb - 2 * half : lb;
      diff  = sa - sb;
      e.d   = 32'(la - lb) & MASK;
      e.bo  = (la < lb);
      e.ov  = (diff >= half) || (diff < -half);
      e.due = due;
      return e;
    endfunction

    // Protocol model: an op occupies W edges; a new start is taken when idle
    // or on the edge that finishes the current op.
    always @(posedge clk) begin : mdl
      bit acc;
      cyc++;
      rst_seen = rst;
      if (rst) begin
        rem = 0;
        q.delete();
        armed = 1;
      end else begin
        acc = start && (rem <= 1);
        if (rem > 0) rem--;
        if (acc) begin
          q.push_back(model(32'(a), 32'(b), cyc + W));
          rem = W;
        end
      end
      exp_busy = (rem > 0);
    end

    always @(negedge clk) begin : mon
      exp_t e;
      if (armed) begin
        if (rst_seen) begin
          chk($sformatf("w%0d rst busy", W), 32'(busy), 0);
          chk($sformatf("w%0d rst done", W), 32'(done), 0);
          chk($sformatf("w%0d rst D", W), 32'(d), 0);
          chk($sformatf("w%0d rst Bout", W), 32'(bout), 0);
          chk($sformatf("w%0d rst OVF", W), 32'(ovf), 0);
          last_d  = 0;
          last_bo = 0;
          last_ov = 0;
        end else begin
          chk($sformatf("w%0d busy", W), 32'(busy), 32'(exp_busy));
          if (done) begin
            if (q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL w%0d unexpected done: got done=1 expected no result pending at %0t", W, $time);
            end else begin
              e = q.pop_front();
              chk($sformatf("w%0d D", W), 32'(d), e.d);
              chk($sformatf("w%0d Bout", W), 32'(bout), 32'(e.bo));
              chk($sformatf("w%0d OVF", W), 32'(ovf), 32'(e.ov));
              chk($sformatf("w%0d done cycle", W), 32'(cyc), 32'(e.due));
              last_d  = e.d;
              last_bo = e.bo;
              last_ov = e.ov;
            end
          end else begin
            chk($sformatf("w%0d D hold", W), 32'(d), last_d);
            chk($sformatf("w%0d Bout hold", W), 32'(bout), 32'(last_bo));
            chk($sformatf("w%0d OVF hold", W), 32'(ovf), 32'(last_ov));
            if (q.size() > 0 && q[0].due <= cyc) begin
              tests++;
              fails++;
              $display("FAIL w%0d missing done: got done=0 expected done at cycle %0d", W, q[0].due);
              void'(q.pop_front());
            end
          end
        end
      end
    end

    task automatic op(logic [W-1:0] x, logic [W-1:0] y, int gap);
      @(negedge clk);
      start = 1'b1;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
      repeat (W + gap) @(negedge clk);
    endtask

    task automatic rand_ops(int n);
      for (int i = 0; i < n; i++)
        op(W'($urandom), W'($urandom), $urandom_range(0, 3) - 1);
    endtask

    if (W == 8) begin : stim
      initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        op(W'(8'h05), W'(8'h03), 1);
        op(W'(8'h03), W'(8'h05), 1);
        op(W'(8'h80), W'(8'h01), 1);
        op(W'(8'hFF), W'(8'hFF), 1);
        // start re-pulsed with new operands mid-operation must be ignored
        @(negedge clk);
        start = 1'b1; a = W'(8'h10); b = W'(8'h01);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = W'(8'h00); b = W'(8'hFF);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        // held start chains operations
        start = 1'b1; a = W'(8'h20); b = W'(8'h10);
        repeat (32) @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        // reset four cycles into an operation
        start = 1'b1; a = W'(8'h77); b = W'(8'h12);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        op(W'(8'h40), W'(8'hC0), 1);
        rand_ops(40);
        repeat (W + 4) @(negedge clk);
        chk("w8 drain", 32'(q.size()), 0);
        fin[g] = 1'b1;
      end
    end else begin : stim
      initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        op(1'b0, 1'b0, 1);
        op(1'b0, 1'b1, 1);
        op(1'b1, 1'b0, 1);
        op(1'b1, 1'b1, 1);
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 12; i++) begin
          a = W'($urandom_range(0, 1));
          b = W'($urandom_range(0, 1));
          @(negedge clk);
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        rand_ops(30);
        repeat (W + 4) @(negedge clk);
        chk("w1 drain", 32'(q.size()), 0);
        fin[g] = 1'b1;
      end
    end
  end

  initial begin
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (fin[0] && fin[1]) break;
    end
    if (!(fin[0] && fin[1])) begin
      tests++;
      fails++;
      $display("FAIL timeout: got unfinished stimulus expected completion within 20000 cycles");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
